// File: rtl/instr_fetch.sv
// Instruction fetch unit: holds the PC, addresses the combinational ROM and hands
// {instr, pc} to decode over valid/ready. Define FETCH_SKID_EN for a 2-entry output FIFO.
module instr_fetch #(
    parameter int unsigned WIDTH               = 32,
    parameter int unsigned INSTRACTION_NUMBERS = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    output logic [WIDTH-1:0] imem_addr,
    input  logic [WIDTH-1:0] imem_data,
    input  logic             redirect,
    input  logic [WIDTH-1:0] redirect_target,
    output logic [WIDTH-1:0] instr,
    output logic [WIDTH-1:0] instr_pc,
    output logic             instr_valid,
    input  logic             instr_ready,
    output logic             halted
);

    // One extra bit so a program size of 2^WIDTH still compares correctly.
    localparam logic [WIDTH:0] LIMIT = (WIDTH+1)'(INSTRACTION_NUMBERS);

    logic [WIDTH-1:0] pc_q, pc_d;
    logic             buffer_can_accept;
    logic             fetch;

    assign imem_addr = pc_q;
    assign halted    = ({1'b0, pc_q} >= LIMIT);
    assign fetch     = en && !halted && !redirect && buffer_can_accept;

    always_comb begin
        pc_d = pc_q;
        if (redirect) begin
            pc_d = redirect_target;
        end else if (fetch) begin
            pc_d = pc_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q <= '0;
        end else begin
            pc_q <= pc_d;
        end
    end

`ifdef FETCH_SKID_EN
    // Entry 0 is the head presented to decode; entry 1 is the skid slot.
    logic [WIDTH-1:0] e0_instr_q, e0_instr_d, e0_pc_q, e0_pc_d;
    logic [WIDTH-1:0] e1_instr_q, e1_instr_d, e1_pc_q, e1_pc_d;
    logic [1:0]       count_q, count_d;
    logic             pop;

    assign buffer_can_accept = (count_q < 2'd2);
    assign pop               = (count_q != 2'd0) && instr_ready;
    assign instr_valid       = (count_q != 2'd0);
    assign instr             = e0_instr_q;
    assign instr_pc          = e0_pc_q;

    always_comb begin
        e0_instr_d = e0_instr_q;
        e0_pc_d    = e0_pc_q;
        e1_instr_d = e1_instr_q;
        e1_pc_d    = e1_pc_q;
        count_d    = count_q;
        if (redirect) begin
            count_d = 2'd0;
        end else if (pop && fetch) begin
            // Only reachable with one entry held: the new word replaces the head.
            e0_instr_d = imem_data;
            e0_pc_d    = pc_q;
        end else if (pop) begin
            if (count_q == 2'd2) begin
                e0_instr_d = e1_instr_q;
                e0_pc_d    = e1_pc_q;
                count_d    = 2'd1;
            end else begin
                count_d = 2'd0;
            end
        end else if (fetch) begin
            if (count_q == 2'd0) begin
                e0_instr_d = imem_data;
                e0_pc_d    = pc_q;
                count_d    = 2'd1;
            end else begin
                e1_instr_d = imem_data;
                e1_pc_d    = pc_q;
                count_d    = 2'd2;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            e0_instr_q <= '0;
            e0_pc_q    <= '0;
            e1_instr_q <= '0;
            e1_pc_q    <= '0;
            count_q    <= 2'd0;
        end else begin
            e0_instr_q <= e0_instr_d;
            e0_pc_q    <= e0_pc_d;
            e1_instr_q <= e1_instr_d;
            e1_pc_q    <= e1_pc_d;
            count_q    <= count_d;
        end
    end
`else
    logic [WIDTH-1:0] instr_q, instr_d, ipc_q, ipc_d;
    logic             valid_q, valid_d;

    assign buffer_can_accept = !valid_q || instr_ready;
    assign instr_valid       = valid_q;
    assign instr             = instr_q;
    assign instr_pc          = ipc_q;

    always_comb begin
        instr_d = instr_q;
        ipc_d   = ipc_q;
        valid_d = valid_q;
        if (redirect) begin
            valid_d = 1'b0;
        end else if (fetch) begin
            instr_d = imem_data;
            ipc_d   = pc_q;
            valid_d = 1'b1;
        end else if (valid_q && instr_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            instr_q <= '0;
            ipc_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            instr_q <= instr_d;
            ipc_q   <= ipc_d;
            valid_q <= valid_d;
        end
    end
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: queue-based model of the decode port checked every cycle,
// plus literal expectations for the directed scenarios.
module tb_instr_fetch;

    localparam int unsigned N = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0;
    logic        redirect = 1'b0;
    logic        instr_ready = 1'b0;
    logic [31:0] redirect_target = '0;
    logic [31:0] imem_addr, imem_data, instr, instr_pc;
    logic        instr_valid, halted;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [31:0] w;
        logic [31:0] p;
    } ent_t;

    ent_t        mq[$];
    ent_t        acc[$];
    logic [31:0] mpc = '0;
    bit          check_en = 1'b0;

`ifdef FETCH_SKID_EN
    localparam logic [31:0] BP_PC = 32'd3;
`else
    localparam logic [31:0] BP_PC = 32'd2;
`endif

    function automatic logic [31:0] memf(input logic [31:0] a);
        if (a < N) return 32'hA0A0_0000 + a;
        return 32'hBAD0_0000 ^ a;
    endfunction

    assign imem_data = memf(imem_addr);

    instr_fetch #(.WIDTH(32), .INSTRACTION_NUMBERS(N)) dut (
        .clk(clk), .rst(rst), .en(en),
        .imem_addr(imem_addr), .imem_data(imem_data),
        .redirect(redirect), .redirect_target(redirect_target),
        .instr(instr), .instr_pc(instr_pc), .instr_valid(instr_valid),
        .instr_ready(instr_ready), .halted(halted)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Queue model: capacity and acceptance follow the handshake rules directly.
    task automatic model_step();
        bit   v, pop, h, can;
        ent_t e;
        v   = mq.size() > 0;
        pop = v && instr_ready;
        h   = mpc >= N;
`ifdef FETCH_SKID_EN
        can = mq.size() < 2;
`else
        can = !v || instr_ready;
`endif
        if (redirect) begin
            mq.delete();
            mpc = redirect_target;
        end else begin
            if (pop) acc.push_back(mq.pop_front());
            if (en && !h && can) begin
                e.w = memf(mpc);
                e.p = mpc;
                mq.push_back(e);
                mpc = mpc + 1;
            end
        end
    endtask

    task automatic cyc(input bit e, input bit r, input bit rd, input logic [31:0] t);
        @(negedge clk);
        en = e; instr_ready = r; redirect = rd; redirect_target = t;
        @(posedge clk);
        model_step();
    endtask

    always @(negedge clk) begin
        if (check_en) begin
            chk("valid", {31'd0, instr_valid}, {31'd0, mq.size() > 0});
            chk("imem_addr", imem_addr, mpc);
            chk("halted", {31'd0, halted}, {31'd0, mpc >= N});
            if (mq.size() > 0) begin
                chk("instr", instr, mq[0].w);
                chk("instr_pc", instr_pc, mq[0].p);
            end
        end
    end

    task automatic lit_word(input string name, input logic [31:0] w, input logic [31:0] p);
        chk({name, "_valid"}, {31'd0, instr_valid}, 32'd1);
        chk({name, "_instr"}, instr, w);
        chk({name, "_pc"}, instr_pc, p);
    endtask

    task automatic lit_reset(input string name);
        chk({name, "_valid"}, {31'd0, instr_valid}, 32'd0);
        chk({name, "_instr"}, instr, 32'd0);
        chk({name, "_pc"}, instr_pc, 32'd0);
        chk({name, "_addr"}, imem_addr, 32'd0);
        chk({name, "_halted"}, {31'd0, halted}, 32'd0);
    endtask

    initial begin
        #1 lit_reset("reset");
        @(negedge clk);
        rst = 1'b0;
        check_en = 1'b1;

        // Straight-line run to the end of the program.
        repeat (5) cyc(1, 1, 0, 0);
        #1;
        chk("run_acc_n", acc.size(), 32'd4);
        chk("run_acc0", acc[0].w, 32'hA0A0_0000);
        chk("run_acc1", acc[1].w, 32'hA0A0_0001);
        chk("run_acc2", acc[2].w, 32'hA0A0_0002);
        chk("run_acc3", acc[3].w, 32'hA0A0_0003);
        chk("run_acc3_pc", acc[3].p, 32'd3);
        chk("run_end_addr", imem_addr, 32'd4);
        chk("run_end_halted", {31'd0, halted}, 32'd1);
        chk("run_end_valid", {31'd0, instr_valid}, 32'd0);

        // Redirect out of the halted state.
        cyc(1, 1, 1, 0);
        #1 chk("unhalt", {31'd0, halted}, 32'd0);
        chk("unhalt_valid", {31'd0, instr_valid}, 32'd0);
        cyc(1, 1, 0, 0);
        #1 lit_word("unhalt_a0", 32'hA0A0_0000, 32'd0);

        // Backpressure while A1 is presented.
        cyc(1, 1, 0, 0);
        #1 lit_word("bp_a1", 32'hA0A0_0001, 32'd1);
        acc.delete();
        repeat (3) cyc(1, 0, 0, 0);
        #1 lit_word("bp_hold", 32'hA0A0_0001, 32'd1);
        chk("bp_pc", imem_addr, BP_PC);
        repeat (3) cyc(1, 1, 0, 0);
        #1;
        chk("bp_acc_n", acc.size(), 32'd3);
        chk("bp_acc0", acc[0].w, 32'hA0A0_0001);
        chk("bp_acc1", acc[1].w, 32'hA0A0_0002);
        chk("bp_acc2", acc[2].w, 32'hA0A0_0003);
        chk("bp_drained", {31'd0, instr_valid}, 32'd0);

        // Redirect while A2 is valid and ready is high.
        cyc(1, 1, 1, 0);
        repeat (3) cyc(1, 1, 0, 0);
        #1 lit_word("rd_a2", 32'hA0A0_0002, 32'd2);
        acc.delete();
        cyc(1, 1, 1, 1);
        #1 chk("rd_flush", {31'd0, instr_valid}, 32'd0);
        chk("rd_no_accept", acc.size(), 32'd0);
        cyc(1, 1, 0, 0);
        #1 lit_word("rd_a1", 32'hA0A0_0001, 32'd1);
        cyc(1, 1, 0, 0);
        #1 lit_word("rd_a2b", 32'hA0A0_0002, 32'd2);
        chk("rd_acc0", acc[0].w, 32'hA0A0_0001);

        // Redirect beyond the program sets halted.
        cyc(1, 1, 1, 7);
        #1 chk("oor_halted", {31'd0, halted}, 32'd1);
        cyc(1, 1, 0, 0);
        #1 chk("oor_pc_hold", imem_addr, 32'd7);
        chk("oor_valid", {31'd0, instr_valid}, 32'd0);

        // Fetch disable after A0.
        cyc(1, 1, 1, 0);
        cyc(1, 1, 0, 0);
        #1 lit_word("en_a0", 32'hA0A0_0000, 32'd0);
        repeat (2) cyc(0, 1, 0, 0);
        #1 chk("en_off_valid", {31'd0, instr_valid}, 32'd0);
        chk("en_off_pc", imem_addr, 32'd1);
        cyc(1, 1, 0, 0);
        #1 lit_word("en_resume", 32'hA0A0_0001, 32'd1);

        // Asynchronous reset between edges.
        cyc(1, 1, 0, 0);
        @(negedge clk);
        #1 rst = 1'b1;
        en = 1'b0; redirect = 1'b0;
        mq.delete();
        mpc = '0;
        #1 lit_reset("async_rst");
        #1 rst = 1'b0;
        cyc(1, 1, 0, 0);
        #1 lit_word("post_rst_a0", 32'hA0A0_0000, 32'd0);
        cyc(1, 1, 0, 0);
        #1 lit_word("post_rst_a1", 32'hA0A0_0001, 32'd1);

        @(negedge clk);
        check_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch unit: the requesting side of the combinational instruction ROM (`instructions`). Holds the program counter and drives the ROM word address. Registers each returned word with its PC and hands it to decode over a valid/ready handshake. Supports branch/jump redirects and halts fetch at the end of the loaded program.

## Interface
Parameters:
- WIDTH, 32, instruction word and PC width
- INSTRACTION_NUMBERS, 1, number of ROM words; valid PCs are 0..INSTRACTION_NUMBERS-1

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- en  in  1  fetch enable; low stops new fetches, buffered words still drain
- imem_addr  out  WIDTH  ROM word address, equal to pc (combinational from the register)
- imem_data  in  WIDTH  ROM read data, combinational from imem_addr
- redirect  in  1  branch/jump taken this cycle
- redirect_target  in  WIDTH  new PC (word index)
- instr  out  WIDTH  instruction to decode
- instr_pc  out  WIDTH  PC of instr
- instr_valid  out  1  instr/instr_pc valid
- instr_ready  in  1  decode accepts the word when valid && ready at the clock edge
- halted  out  1  pc >= INSTRACTION_NUMBERS; no fetch is issued

## Operation
- State: pc; output buffer (1 or 2 entries, see Configuration) of {instr, instr_pc}.
- Fetch condition, evaluated each cycle: `en && !halted && !redirect && buffer_can_accept`. On the edge:
  - push {imem_data, pc} into the buffer
  - pc <= pc + 1, modulo 2^WIDTH; no extra wrap logic
- Pop: instr_valid && instr_ready. Push and pop in the same cycle are allowed.
- Redirect has highest priority, above fetch, pop and en:
  - buffer flushed, so instr_valid goes to 0 on the next edge
  - pc <= redirect_target
  - no push that cycle
  - the word presented during the redirect cycle is dropped even if instr_ready=1; decode must not count it as consumed
- Halted:
  - halted = (pc >= INSTRACTION_NUMBERS), derived from registered pc only
  - while halted, pc holds and the buffer drains normally
  - a redirect to an in-range target clears halted on the next edge; an out-of-range target sets it
- en low: pc holds, no push, pops continue.
- Output register values when instr_valid=0 are don't-care, except after reset.

## Timing
- Reset values (async, immediate): pc=0, instr=0, instr_pc=0, instr_valid=0, halted=(INSTRACTION_NUMBERS==0). imem_addr=0.
- Reset mid-operation: all state cleared within the same cycle; buffered words are lost.
- Fetch latency: word at pc is sampled on the edge where the fetch condition is true. instr_valid=1 from that edge.
  - first instruction after reset release with en=1: valid after the first edge
- Redirect sampled at edge N:
  - edge N: instr_valid=0, pc=target
  - edge N+1: instr=mem[target] valid, given en=1 and in range
  - redirect-to-use latency is 2 cycles
- Steady state with instr_ready held 1: one instruction per cycle, PCs consecutive.
- Backpressure: instr, instr_pc and instr_valid hold stable while instr_valid && !instr_ready.

## Configuration
- FETCH_SKID_EN defined:
  - 2-entry FIFO buffer
  - buffer_can_accept = (count < 2), a registered-only term; instr_ready does not reach the pc/fetch path
  - fetch runs one word ahead of decode
  - after ready drops, at most one further word is fetched, then fetch stalls
- FETCH_SKID_EN undefined:
  - single output register
  - buffer_can_accept = !instr_valid || instr_ready, a combinational path from instr_ready
  - zero extra buffering
- Both builds must give identical instruction/PC sequences at the decode port for the same accepted-handshake pattern.

## Test plan
Default setup: INSTRACTION_NUMBERS=4, mem = {A0, A1, A2, A3}.
- Reset release, en=1, ready=1:
  - instr/instr_pc = A0/0, A1/1, A2/2, A3/3 on consecutive edges
  - then halted=1, instr_valid=0, pc=4
- Backpressure: ready=0 for 3 cycles while A1 is presented:
  - A1/1 held stable
  - without skid: pc stays 2
  - with FETCH_SKID_EN: pc reaches 3 and stops
  - on ready=1, A2, A3 follow with no loss or duplication
- redirect=1, target=1 while A2 is valid and ready=1:
  - A2 is not counted as accepted
  - next edge: instr_valid=0
  - following edge: A1/1, then A2/2
- While halted, redirect with target=0: halted=0 next edge; A0/0 valid the edge after.
- en=0 for 2 cycles after A0 is fetched: A0 drains, instr_valid=0, pc holds 1; en=1 resumes with A1/1.
- rst pulsed asynchronously mid-stream (between edges): outputs go to 0 immediately; after release the sequence restarts at A0/0.
